// File: rtl/mips_pkg.sv
// Shared MIPS encodings and ID-stage record types.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [2:0] {
        I_NOP, I_R, I_ADDI, I_LW, I_SW, I_BEQ, I_BNE, I_J
    } iclass_t;

    typedef struct packed {
        logic [2:0] alu_ctl;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
    } ctl_t;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        logic [31:0] seimm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wrreg;
        ctl_t        ctl;
    } s3_t;

endpackage

// File: rtl/regfile.sv
// 2-read/1-write GPR file, r0 reads zero, write-first bypass on same-cycle reads.
module regfile #(
    parameter int NREG     = 32,
    parameter bit RESET_WE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    localparam int AW = $clog2(NREG);

    logic [31:0] mem [NREG];
    logic        wr_en;

    assign wr_en = we && (wa != 5'd0);

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : (wr_en && wa == ra1) ? wd : mem[ra1[AW-1:0]];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : (wr_en && wa == ra2) ? wd : mem[ra2[AW-1:0]];

    if (RESET_WE) begin : g_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NREG; i++) mem[i] <= '0;
            end else if (wr_en) begin
                mem[wa[AW-1:0]] <= wd;
            end
        end
    end else begin : g_nrst
        always_ff @(posedge clk) begin
            if (wr_en) mem[wa[AW-1:0]] <= wd;
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: decode, hazard detection, branch resolution, ID/EX register.
// Optional macro ID_BRANCH_FWD_EN forwards a MEM-stage ALU result into the branch comparator.
module id_stage
    import mips_pkg::*;
#(
    parameter int NREG     = 32,
    parameter bit RESET_WE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst_s2,
    input  logic [31:0] pc4_s2,
    input  logic        regwrite_s5,
    input  logic [4:0]  wrreg_s5,
    input  logic [31:0] wrdata_s5,
    input  logic        regwrite_s4,
    input  logic        memread_s4,
    input  logic [4:0]  wrreg_s4,
    input  logic [31:0] alurslt_s4,
    output logic        stall_s1_s2,
    output logic        pcsrc,
    output logic [31:0] baddr_s2,
    output logic        branch_flush,
    output logic [31:0] rdata1_s3,
    output logic [31:0] rdata2_s3,
    output logic [31:0] seimm_s3,
    output logic [4:0]  rs_s3,
    output logic [4:0]  rt_s3,
    output logic [4:0]  wrreg_s3,
    output logic [2:0]  alu_ctl_s3,
    output logic        alusrc_s3,
    output logic        memread_s3,
    output logic        memwrite_s3,
    output logic        memtoreg_s3,
    output logic        regwrite_s3
);
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] seimm, rv1, rv2, cmp_a, cmp_b;
    logic [2:0]  r_alu;
    iclass_t     cls;
    ctl_t        ctl;
    logic [4:0]  wrreg_d;
    logic        use_rs, use_rt, is_br, hit_s3, hit_s4, equal, taken;
    s3_t         s3_q;

    assign op    = inst_s2[31:26];
    assign rs    = inst_s2[25:21];
    assign rt    = inst_s2[20:16];
    assign rd    = inst_s2[15:11];
    assign funct = inst_s2[5:0];
    assign seimm = {{16{inst_s2[15]}}, inst_s2[15:0]};

    always_comb begin
        cls   = I_NOP;
        r_alu = ALU_AND;
        case (op)
            OP_RTYPE: begin
                cls = I_R;
                case (funct)
                    FN_ADD:  r_alu = ALU_ADD;
                    FN_SUB:  r_alu = ALU_SUB;
                    FN_AND:  r_alu = ALU_AND;
                    FN_OR:   r_alu = ALU_OR;
                    FN_SLT:  r_alu = ALU_SLT;
                    default: cls = I_NOP;
                endcase
            end
            OP_ADDI: cls = I_ADDI;
            OP_LW:   cls = I_LW;
            OP_SW:   cls = I_SW;
            OP_BEQ:  cls = I_BEQ;
            OP_BNE:  cls = I_BNE;
            OP_J:    cls = I_J;
            default: cls = I_NOP;
        endcase
    end

    always_comb begin
        ctl     = '0;
        wrreg_d = 5'd0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        case (cls)
            I_R: begin
                ctl.alu_ctl  = r_alu;
                ctl.regwrite = 1'b1;
                wrreg_d      = rd;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            I_ADDI, I_LW: begin
                ctl.alu_ctl  = ALU_ADD;
                ctl.alusrc   = 1'b1;
                ctl.regwrite = 1'b1;
                ctl.memread  = (cls == I_LW);
                ctl.memtoreg = (cls == I_LW);
                wrreg_d      = rt;
                use_rs       = 1'b1;
            end
            I_SW: begin
                ctl.alu_ctl  = ALU_ADD;
                ctl.alusrc   = 1'b1;
                ctl.memwrite = 1'b1;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            I_BEQ, I_BNE: begin
                ctl.alu_ctl = ALU_SUB;
                use_rs      = 1'b1;
                use_rt      = 1'b1;
            end
            default: ;
        endcase
    end

    regfile #(.NREG(NREG), .RESET_WE(RESET_WE)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rv1),
        .rd2   (rv2),
        .we    (regwrite_s5),
        .wa    (wrreg_s5),
        .wd    (wrdata_s5)
    );

    assign is_br  = (cls == I_BEQ) || (cls == I_BNE);
    assign hit_s3 = (wrreg_s3 != 5'd0) && ((use_rs && rs == wrreg_s3) || (use_rt && rt == wrreg_s3));
    assign hit_s4 = (wrreg_s4 != 5'd0) && ((use_rs && rs == wrreg_s4) || (use_rt && rt == wrreg_s4));

`ifdef ID_BRANCH_FWD_EN
    logic fwd_ok;
    assign fwd_ok = regwrite_s4 && !memread_s4 && (wrreg_s4 != 5'd0);
    assign cmp_a  = (fwd_ok && rs == wrreg_s4) ? alurslt_s4 : rv1;
    assign cmp_b  = (fwd_ok && rt == wrreg_s4) ? alurslt_s4 : rv2;
    assign stall_s1_s2 = (memread_s3 && hit_s3)
                       || (is_br && regwrite_s3 && hit_s3)
                       || (is_br && memread_s4 && hit_s4);
`else
    logic unused_alurslt;
    assign unused_alurslt = ^alurslt_s4;
    assign cmp_a = rv1;
    assign cmp_b = rv2;
    // A MEM-stage ALU producer is only visible to the comparator once it reaches WB.
    assign stall_s1_s2 = (memread_s3 && hit_s3)
                       || (is_br && regwrite_s3 && hit_s3)
                       || (is_br && memread_s4 && hit_s4)
                       || (is_br && regwrite_s4 && !memread_s4 && hit_s4);
`endif

    assign equal = (cmp_a == cmp_b);
    assign taken = ((cls == I_BEQ) && equal) || ((cls == I_BNE) && !equal) || (cls == I_J);
    assign pcsrc        = taken && !stall_s1_s2;
    assign branch_flush = pcsrc;
    assign baddr_s2 = (cls == I_J) ? {pc4_s2[31:28], inst_s2[25:0], 2'b00}
                                   : pc4_s2 + {seimm[29:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           s3_q <= '0;
        else if (stall_s1_s2) s3_q <= '0;
        else                  s3_q <= '{rdata1: rv1, rdata2: rv2, seimm: seimm,
                                        rs: rs, rt: rt, wrreg: wrreg_d, ctl: ctl};
    end

    assign rdata1_s3   = s3_q.rdata1;
    assign rdata2_s3   = s3_q.rdata2;
    assign seimm_s3    = s3_q.seimm;
    assign rs_s3       = s3_q.rs;
    assign rt_s3       = s3_q.rt;
    assign wrreg_s3    = s3_q.wrreg;
    assign alu_ctl_s3  = s3_q.ctl.alu_ctl;
    assign alusrc_s3   = s3_q.ctl.alusrc;
    assign memread_s3  = s3_q.ctl.memread;
    assign memwrite_s3 = s3_q.ctl.memwrite;
    assign memtoreg_s3 = s3_q.ctl.memtoreg;
    assign regwrite_s3 = s3_q.ctl.regwrite;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NREG, 32, number of GPRs (r0 hardwired zero).
REQ-002 SHALL have parameter RESET_WE, 1, 1 = register file cleared by reset; 0 = contents undefined after reset.
REQ-003 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-004 SHALL have ports: inst_s2 in 32 IF/ID instruction; pc4_s2 in 32 IF/ID PC+4.
REQ-005 SHALL have ports: regwrite_s5 in 1, wrreg_s5 in 5, wrdata_s5 in 32 (WB write port).
REQ-006 SHALL have ports: regwrite_s4 in 1, memread_s4 in 1, wrreg_s4 in 5, alurslt_s4 in 32 (MEM-stage status).
REQ-007 SHALL have ports: stall_s1_s2 out 1; pcsrc out 1; baddr_s2 out 32; branch_flush out 1 (zeroes IF/ID).
REQ-008 SHALL have ports: rdata1_s3, rdata2_s3, seimm_s3 out 32; rs_s3, rt_s3, wrreg_s3 out 5; alu_ctl_s3 out 3; alusrc_s3, memread_s3, memwrite_s3, memtoreg_s3, regwrite_s3 out 1.

Function
REQ-009 SHALL decode R-type add/sub/and/or/slt, addi, lw, sw, beq, bne, j; any other encoding SHALL decode as NOP (all write/mem controls 0).
REQ-010 SHALL read rs/rt combinationally; WB write on posedge clk when regwrite_s5 and wrreg_s5 != 0; same-cycle read of wrreg_s5 SHALL return wrdata_s5 (write-first bypass).
REQ-011 SHALL register all _s3 outputs on posedge clk: one-cycle ID-to-EX latency.
REQ-012 wrreg_s3 SHALL be rd for R-type, rt for addi/lw, 0 for sw/beq/bne/j/NOP.
REQ-013 seimm_s3 SHALL be imm16 sign-extended to 32 bits.
REQ-014 Load-use hazard: memread_s3=1, wrreg_s3 != 0, and wrreg_s3 equals a source register used by inst_s2 -> stall_s1_s2=1 and bubble (all controls 0) into _s3 next cycle.
REQ-015 Branch resolves in ID: equal = (rs value == rt value); pcsrc=1 for beq&equal, bne&!equal, or j, only when stall_s1_s2=0.
REQ-016 baddr_s2 SHALL be pc4_s2 + (seimm<<2) for branches, {pc4_s2[31:28], target26, 2'b00} for j; modulo-2^32 wrap.
REQ-017 Branch source equal to nonzero wrreg_s3 with regwrite_s3=1 SHALL stall one cycle; if that producer is a load, stall continues while it sits in MEM (memread_s4).
REQ-018 branch_flush SHALL equal pcsrc; stall_s1_s2 SHALL override pcsrc (pcsrc forced 0 while stalled).
REQ-019 While stalled, _s3 receives a bubble; IF/ID holding is upstream's duty.

Reset
REQ-020 rst_n low SHALL asynchronously clear all _s3 registers to 0 (bubble); combinational outputs follow decode of inst_s2.
REQ-021 RESET_WE=1: all GPRs cleared; reset mid-stall SHALL cancel the stall on release.

Configuration
REQ-022 Macro ID_BRANCH_FWD_EN defined: branch comparator SHALL take alurslt_s4 when regwrite_s4, !memread_s4, wrreg_s4 matches a nonzero source.
REQ-023 Macro undefined: that case SHALL instead stall until the value arrives via WB bypass (one extra stall cycle).

Structure
REQ-024 Package mips_pkg SHALL hold opcode/funct constants, alu_ctl encodings (ADD=010, SUB=110, AND=000, OR=001, SLT=111).
REQ-025 Register file SHALL be sub-module regfile (2R/1W, write-first); decode, hazard and branch logic stay in id_stage.

Verification
REQ-026 WB writes r5=0x1234 while inst_s2 reads r5 same cycle -> rdata1_s3=0x00001234 next cycle.
REQ-027 lw r2 in EX, inst_s2 = add r3,r2,r4 -> stall_s1_s2=1 one cycle, bubble in _s3, add issues the following cycle.
REQ-028 beq r1,r1,+3 at pc4_s2=0x100 -> pcsrc=1, branch_flush=1, baddr_s2=0x10C; bne same -> pcsrc=0.
REQ-029 j 0x40 with pc4_s2=0xF0000004 -> baddr_s2=0xF0000100; beq offset -1 at pc4_s2=0x0 -> baddr_s2=0xFFFFFFFC.
REQ-030 addi r6 in MEM, beq r6,r0: with ID_BRANCH_FWD_EN zero stall cycles; without, one stall cycle; write to r0 -> r0 reads 0.
REQ-031 rst_n asserted mid-stall -> all _s3 outputs 0 immediately, stall_s1_s2 0 after release with NOP in IF/ID.
